im_access_ctrl: RTL and testbench



---
 rtl/im_access_ctrl_pkg.sv | 24 ++
 rtl/im_access_ctrl_if.sv | 35 +++
 rtl/im_access_ctrl_arbiter.sv | 42 ++++
 rtl/im_access_ctrl.sv | 132 +++++++++++++
 tb/tb_im_access_ctrl.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/im_access_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// im_ctrl_pkg : shared types and constants for the instruction-memory
//               access controller.  Rev 1.0
// ============================================================================
package im_ctrl_pkg;

  localparam int ADDR_W = 10;
  localparam int BYTES  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    DONE = 2'd2,
    WR   = 2'd3
  } state_t;

  typedef enum logic {
    GNT_FETCH  = 1'b0,
    GNT_LOADER = 1'b1
  } gnt_t;

endpackage : im_ctrl_pkg
`default_nettype wire

// File: rtl/im_access_ctrl_if.sv
`default_nettype none
// ============================================================================
// im_access_ctrl_if : fetch, loader and byte-memory signals of the controller.
//                     Rev 1.0
// ============================================================================
interface im_access_ctrl_if #(
  parameter int ADDR_W = im_ctrl_pkg::ADDR_W
);
  logic              FetchReq;
  logic [ADDR_W-1:0] FetchPC;
  logic [31:0]       Instruction;
  logic              FetchValid;
  logic              LdValid;
  logic [ADDR_W-1:0] LdAddr;
  logic [31:0]       LdData;
  logic              LdReady;
  logic [ADDR_W-1:0] MemAddr;
  logic              MemWrEn;
  logic [7:0]        MemWrData;
  logic [7:0]        MemRdData;
  logic              Busy;

  // Environment side: CPU, loader and the memory array itself.
  modport master (
    output FetchReq, FetchPC, LdValid, LdAddr, LdData, MemRdData,
    input  Instruction, FetchValid, LdReady, MemAddr, MemWrEn, MemWrData, Busy
  );

  modport slave (
    input  FetchReq, FetchPC, LdValid, LdAddr, LdData, MemRdData,
    output Instruction, FetchValid, LdReady, MemAddr, MemWrEn, MemWrData, Busy
  );

endinterface : im_access_ctrl_if
`default_nettype wire

// File: rtl/im_access_ctrl_arbiter.sv
`default_nettype none
// ============================================================================
// im_rr_arbiter : two-input round-robin arbiter, req[0]=fetch, req[1]=loader.
//                 Rev 1.0
// ============================================================================
module im_rr_arbiter
  import im_ctrl_pkg::*;
(
  input  wire logic       clk,
  input  wire logic       rst_n,
  input  wire logic       i_en,
  input  wire logic [1:0] i_req,
  output logic      [1:0] o_gnt
);

  gnt_t r_last;

  always_comb begin
    o_gnt = 2'b00;
    if (i_en) begin
      case (i_req)
        2'b01:   o_gnt = 2'b01;
        2'b10:   o_gnt = 2'b10;
        // Tie goes to whoever was not served last.
        2'b11:   o_gnt = (r_last == GNT_FETCH) ? 2'b10 : 2'b01;
        default: o_gnt = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last <= GNT_LOADER;
    end else if (o_gnt[0]) begin
      r_last <= GNT_FETCH;
    end else if (o_gnt[1]) begin
      r_last <= GNT_LOADER;
    end
  end

endmodule : im_rr_arbiter
`default_nettype wire

// File: rtl/im_access_ctrl.sv
`default_nettype none
// ============================================================================
// im_access_ctrl : shares one byte-wide memory port between CPU fetch (4-byte
//                  big-endian reads) and the program loader (4-byte writes). Rev 1.0
// ============================================================================
module im_access_ctrl #(
  parameter int ADDR_W = im_ctrl_pkg::ADDR_W,
  parameter int BYTES  = im_ctrl_pkg::BYTES
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  im_access_ctrl_if.slave bus
);
  import im_ctrl_pkg::*;

  localparam int                   C_CNT_W  = $clog2(BYTES);
  localparam int                   C_WORD_W = 8 * BYTES;
  localparam logic [C_CNT_W-1:0]   C_LAST   = C_CNT_W'(BYTES - 1);

  state_t                r_state;
  state_t                w_next;
  logic [C_CNT_W-1:0]    r_cnt;
  logic [ADDR_W-1:0]     r_base;
  logic [C_WORD_W-1:0]   r_wdata;
  logic [C_WORD_W-9:0]   r_rdbuf;
  logic [C_WORD_W-1:0]   r_instr;

  logic [1:0]            w_gnt;
  logic                  w_idle;
  logic                  w_last;
  logic [ADDR_W-1:0]     w_addr;
  logic [C_WORD_W-1:0]   w_wr_word;
  logic                  w_unused;

  assign w_idle    = (r_state == IDLE);
  assign w_last    = (r_cnt == C_LAST);
  // Natural ADDR_W-bit overflow gives the modulo-depth wrap for fetches.
  assign w_addr    = r_base + ADDR_W'(r_cnt);
  assign w_wr_word = r_wdata << {r_cnt, 3'b000};
  assign w_unused  = &{1'b0, bus.LdAddr[1:0]};

  im_rr_arbiter u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_idle),
    .i_req ({bus.LdValid, bus.FetchReq}),
    .o_gnt (w_gnt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == RD || r_state == WR) begin
        r_cnt <= r_cnt + 1'b1;
      end else begin
        r_cnt <= '0;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_gnt[0]) begin
          w_next = RD;
        end else if (w_gnt[1]) begin
          w_next = WR;
        end
      end
      RD:      w_next = w_last ? DONE : RD;
      DONE:    w_next = IDLE;
      WR:      w_next = w_last ? IDLE : WR;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    bus.MemAddr    = '0;
    bus.MemWrEn    = 1'b0;
    bus.MemWrData  = '0;
    bus.FetchValid = 1'b0;
    bus.LdReady    = 1'b0;
    case (r_state)
      RD: begin
        bus.MemAddr = w_addr;
      end
      DONE: begin
        bus.FetchValid = 1'b1;
      end
      WR: begin
        bus.MemAddr   = w_addr;
        bus.MemWrEn   = 1'b1;
        bus.MemWrData = w_wr_word[C_WORD_W-1 -: 8];
        bus.LdReady   = w_last;
      end
      default: ;
    endcase
  end

  // Request address/data are captured at grant so later input changes are ignored.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_base  <= '0;
      r_wdata <= '0;
      r_rdbuf <= '0;
      r_instr <= '0;
    end else begin
      if (w_gnt[0]) begin
        r_base <= bus.FetchPC;
      end else if (w_gnt[1]) begin
        r_base  <= {bus.LdAddr[ADDR_W-1:2], 2'b00};
        r_wdata <= bus.LdData;
      end
      if (r_state == RD) begin
        if (w_last) begin
          r_instr <= {r_rdbuf, bus.MemRdData};
        end else begin
          r_rdbuf <= {r_rdbuf[C_WORD_W-17:0], bus.MemRdData};
        end
      end
    end
  end

  assign bus.Instruction = r_instr;
  assign bus.Busy        = !w_idle;

endmodule : im_access_ctrl
`default_nettype wire

// File: tb/tb_im_access_ctrl.sv
`default_nettype none
// ============================================================================
// tb_im_access_ctrl : directed self-checking bench for im_access_ctrl. Rev 1.0
// ============================================================================
module tb_im_access_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  im_access_ctrl_if #(.ADDR_W(10)) bus ();

  im_access_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Byte memory: combinational read, written on the rising edge.
  logic [7:0] mem [1024];
  logic       tb_clr;
  logic       pl_en;
  logic [9:0] pl_addr;
  logic [7:0] pl_data;

  assign bus.MemRdData = mem[bus.MemAddr];

  always @(posedge clk) begin
    if (tb_clr) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
    end else if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end else if (bus.MemWrEn) begin
      mem[bus.MemAddr] <= bus.MemWrData;
    end
  end

  int n_total = 0;
  int n_fail  = 0;

  logic [9:0] ra [4];
  logic [9:0] wa [4];
  logic [7:0] wd [4];
  logic [3:0] wrdy;
  int         na, nw;
  int         cyc;
  bit         ok;
  logic [2:0] order;
  int         nev;
  logic       seen;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [9:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // cyc counts the grant (IDLE) cycle as 1; requests are dropped at completion.
  task automatic run_until(input bit want_fetch, output int c, output bit done);
    c = 1; done = 1'b0; na = 0; nw = 0; wrdy = '0;
    for (int i = 0; i < 30 && !done; i++) begin
      @(negedge clk);
      c++;
      if (bus.MemWrEn) begin
        if (nw < 4) begin
          wa[nw] = bus.MemAddr; wd[nw] = bus.MemWrData; wrdy[nw] = bus.LdReady;
        end
        nw++;
      end else if (bus.Busy && !bus.FetchValid) begin
        if (na < 4) ra[na] = bus.MemAddr;
        na++;
      end
      if (want_fetch ? bus.FetchValid : bus.LdReady) begin
        done = 1'b1;
        bus.FetchReq = 1'b0;
        bus.LdValid  = 1'b0;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; tb_clr = 1'b1; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    bus.FetchReq = 1'b0; bus.FetchPC = '0;
    bus.LdValid = 1'b0; bus.LdAddr = '0; bus.LdData = '0;
    @(negedge clk);
    tb_clr = 1'b0;
    preload(10'h000, 8'h8C);
    preload(10'h001, 8'h01);
    preload(10'h002, 8'h00);
    preload(10'h003, 8'h04);
    preload(10'h3FE, 8'h11);
    preload(10'h3FF, 8'h22);

    // Reset state
    chk("rst_busy",   bus.Busy, 0);
    chk("rst_instr",  bus.Instruction, 0);
    chk("rst_pulses", {bus.FetchValid, bus.LdReady, bus.MemWrEn}, 0);
    chk("rst_mem",    {bus.MemAddr, bus.MemWrData}, 0);
    rst_n = 1'b1;

    // Fetch at 0
    bus.FetchPC = 10'h000; bus.FetchReq = 1'b1;
    run_until(1'b1, cyc, ok);
    chk("f0_done",  ok, 1);
    chk("f0_cyc",   cyc, 6);
    chk("f0_instr", bus.Instruction, 32'h8C010004);
    chk("f0_addrs", {ra[0], ra[1], ra[2], ra[3]}, {10'h000, 10'h001, 10'h002, 10'h003});
    @(negedge clk);
    chk("f0_pulse_once", {bus.FetchValid, bus.Busy}, 2'b00);

    // Loader word at 0x013 -> aligned to 0x010
    bus.LdAddr = 10'h013; bus.LdData = 32'hDEADBEEF; bus.LdValid = 1'b1;
    run_until(1'b0, cyc, ok);
    chk("ld_done",  ok, 1);
    chk("ld_cyc",   cyc, 5);
    chk("ld_addrs", {wa[0], wa[1], wa[2], wa[3]}, {10'h010, 10'h011, 10'h012, 10'h013});
    chk("ld_data",  {wd[0], wd[1], wd[2], wd[3]}, 32'hDEADBEEF);
    chk("ld_ready_last", wrdy, 4'b1000);
    @(negedge clk);
    chk("ld_mem", {mem[10'h010], mem[10'h011], mem[10'h012], mem[10'h013]}, 32'hDEADBEEF);

    // Read-after-write
    bus.FetchPC = 10'h010; bus.FetchReq = 1'b1;
    run_until(1'b1, cyc, ok);
    chk("raw_done",  ok, 1);
    chk("raw_instr", bus.Instruction, 32'hDEADBEEF);
    @(negedge clk);

    // Tie right after reset: fetch, load, fetch while both held
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.FetchPC = 10'h010; bus.LdAddr = 10'h020; bus.LdData = 32'h01020304;
    bus.FetchReq = 1'b1; bus.LdValid = 1'b1;
    order = '0; nev = 0;
    for (int i = 0; i < 40 && nev < 3; i++) begin
      @(negedge clk);
      if (bus.FetchValid) begin
        order = {order[1:0], 1'b1}; nev++;
      end else if (bus.LdReady) begin
        order = {order[1:0], 1'b0}; nev++;
      end
    end
    bus.FetchReq = 1'b0; bus.LdValid = 1'b0;
    chk("arb_events", nev, 3);
    chk("arb_order",  order, 3'b101);
    chk("arb_instr",  bus.Instruction, 32'hDEADBEEF);
    @(negedge clk);
    chk("arb_ld_mem", {mem[10'h020], mem[10'h021], mem[10'h022], mem[10'h023]}, 32'h01020304);

    // Address wrap-around
    preload(10'h000, 8'h33);
    preload(10'h001, 8'h44);
    bus.FetchPC = 10'h3FE; bus.FetchReq = 1'b1;
    run_until(1'b1, cyc, ok);
    chk("wrap_done",  ok, 1);
    chk("wrap_instr", bus.Instruction, 32'h11223344);
    chk("wrap_addrs", {ra[0], ra[1], ra[2], ra[3]}, {10'h3FE, 10'h3FF, 10'h000, 10'h001});
    @(negedge clk);

    // Reset in the middle of a load (WR, cnt=2)
    bus.LdAddr = 10'h031; bus.LdData = 32'hCAFEF00D; bus.LdValid = 1'b1;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen = seen | bus.LdReady;
    end
    chk("mid_wr2", {bus.MemWrEn, bus.MemAddr, bus.MemWrData}, {1'b1, 10'h032, 8'hF0});
    rst_n = 1'b0; bus.LdValid = 1'b0;
    @(negedge clk);
    chk("mid_wren",  bus.MemWrEn, 0);
    chk("mid_busy",  bus.Busy, 0);
    chk("mid_instr", bus.Instruction, 0);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      seen = seen | bus.LdReady;
    end
    chk("mid_no_ldready", seen, 0);
    chk("mid_no_byte3",   mem[10'h033], 8'h00);
    bus.FetchPC = 10'h020; bus.FetchReq = 1'b1;
    run_until(1'b1, cyc, ok);
    chk("post_done",  ok, 1);
    chk("post_cyc",   cyc, 6);
    chk("post_instr", bus.Instruction, 32'h01020304);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_total - n_fail, n_total);
    $finish;
  end

endmodule : tb_im_access_ctrl
`default_nettype wire
